// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for digit (op digit)* with '*' over '+'; EXPR_EVAL_OVF_DETECT_EN adds a sticky overflow flag
module expr_eval (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  in,
  output logic        legal,
  output logic [15:0] result,
  output logic        ovf
);
  typedef enum logic [1:0] {START, NUM, OP, ERR} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_sum, r_term, w_term_nxt;
  logic        r_last_op;
  logic [3:0]  w_d;
  logic        w_dig, w_plus, w_star, w_take_dig, w_take_plus, w_take_star, w_mul;
  assign w_dig       = (in >= 8'd48) && (in <= 8'd57);
  assign w_d         = in[3:0];
  assign w_plus      = in == 8'd43;
  assign w_star      = in == 8'd42;
  assign w_take_dig  = w_dig && (r_state == START || r_state == OP);
  assign w_take_plus = w_plus && r_state == NUM;
  assign w_take_star = w_star && r_state == NUM;
  assign w_mul       = r_state == OP && r_last_op;
  assign legal       = r_state == NUM;
  assign result      = legal ? r_sum + r_term : 16'd0;
`ifdef EXPR_EVAL_OVF_DETECT_EN
  logic        r_ovf;
  logic [19:0] w_prod;
  logic [16:0] w_add, w_res;
  assign w_prod     = {4'd0, r_term} * {16'd0, w_d};
  assign w_term_nxt = w_mul ? w_prod[15:0] : {12'd0, w_d};
  assign w_add      = {1'b0, r_sum} + {1'b0, r_term};
  assign w_res      = {1'b0, r_sum} + {1'b0, w_term_nxt};
  assign ovf        = r_ovf;
  // sticky flag: set when a product, a partial sum or the new result exceeds 16 bits
  always_ff @(posedge clk or posedge clr)
    if (clr) r_ovf <= 1'b0;
    else if ((w_take_dig && ((w_mul && |w_prod[19:16]) || w_res[16])) || (w_take_plus && w_add[16])) r_ovf <= 1'b1;
`else
  assign w_term_nxt = w_mul ? r_term * {12'd0, w_d} : {12'd0, w_d};
  assign ovf        = 1'b0;
`endif
  // state register; ERR holds until clr
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= START;
    else r_state <= w_next;
  // anything not explicitly accepted drops into ERR, and ERR accepts nothing
  always_comb begin
    w_next = w_take_dig ? NUM : (w_take_plus || w_take_star) ? OP : ERR;
  end
  // datapath only moves on accepted characters, so it freezes in ERR
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_sum     <= 16'd0;
      r_term    <= 16'd0;
      r_last_op <= 1'b0;
    end
    else if (w_take_dig) r_term <= w_term_nxt;
    else if (w_take_plus) begin
      r_sum     <= r_sum + r_term;
      r_last_op <= 1'b0;
    end
    else if (w_take_star) r_last_op <= 1'b1;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: string-level reference model with per-cycle compare plus directed literal checks
module tb_expr_eval;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  in = 8'd0;
  logic        legal, ovf;
  logic [15:0] result;
  int checks = 0, errors = 0;
`ifdef EXPR_EVAL_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  expr_eval dut (.clk(clk), .clr(clr), .in(in), .legal(legal), .result(result), .ovf(ovf));

  always #5 clk = ~clk;

  byte q[$];
  bit  m_err = 1'b0, m_ovf = 1'b0;

  // exact value of the accepted text: sum of products, saturated far above 16 bits
  function automatic longint eval_q();
    longint s = 0, p = 1;
    foreach (q[i]) begin
      if (q[i] == "+") begin
        s = s + p;
        p = 1;
      end else if (q[i] != "*") p = p * (q[i] - 48);
      if (p > 64'd1 << 40) p = 64'd1 << 40;
      if (s > 64'd1 << 40) s = 64'd1 << 40;
    end
    return s + p;
  endfunction

  function automatic bit m_legal();
    return !m_err && (q.size() % 2 == 1);
  endfunction

  function automatic logic [15:0] m_result();
    longint v;
    v = eval_q();
    return m_legal() ? 16'(v % 65536) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: consumes one character per edge, reset asynchronously by clr
  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) begin
      q.delete();
      m_err = 1'b0;
      m_ovf = 1'b0;
    end else if (!m_err) begin
      bit isd, iso;
      isd = in >= "0" && in <= "9";
      iso = in == "+" || in == "*";
      if ((q.size() % 2 == 0) ? isd : iso) begin
        q.push_back(in);
        if (isd && eval_q() > 65535) m_ovf = OVF_EN;
      end else m_err = 1'b1;
    end
  end

  // per-cycle compare against the model, well after the edge
  initial forever begin
    @(posedge clk);
    #4;
    chk("cyc_legal", {31'd0, legal}, {31'd0, m_legal()});
    chk("cyc_result", {16'd0, result}, {16'd0, m_result()});
    chk("cyc_ovf", {31'd0, ovf}, {31'd0, m_ovf});
  end

  // drive a string one character per cycle; fresh=1 starts from an async reset
  task automatic run(input string s, input bit fresh);
    if (fresh) begin
      clr = 1'b1;
      #1;
      chk("rst_legal", {31'd0, legal}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      #1 clr = 1'b0;
    end
    in = s[0];
    for (int i = 1; i < s.len(); i++) begin
      @(negedge clk);
      in = s[i];
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input bit l, input logic [15:0] r, input bit o);
    chk({name, "_legal"}, {31'd0, legal}, {31'd0, l});
    chk({name, "_result"}, {16'd0, result}, {16'd0, r});
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, o});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    run("1+2*", 1); settle();
    expect3("prec_mid", 1'b0, 16'd0, 1'b0);
    run("3", 0); settle();
    expect3("prec", 1'b1, 16'd7, 1'b0);
    run("2*3+4*5", 1); settle();
    expect3("mixed", 1'b1, 16'd26, 1'b0);
    run("9*9*9*9*9", 1); settle();
    expect3("pow5", 1'b1, 16'd59049, 1'b0);
    run("*9", 0); settle();
    expect3("pow6", 1'b1, 16'd7153, OVF_EN);
    run("a1", 0); settle();
    expect3("ovf_err", 1'b0, 16'd0, OVF_EN);
    run("9*9*9*9*9+9*9*9*9*9", 1); settle();
    expect3("addwrap", 1'b1, 16'd52562, OVF_EN);
    run("1a+2", 1); settle();
    expect3("illegal", 1'b0, 16'd0, 1'b0);
    run("5", 0); settle();
    expect3("err_abs", 1'b0, 16'd0, 1'b0);
    run("1", 1); settle();
    expect3("dbl1", 1'b1, 16'd1, 1'b0);
    run("2", 0); settle();
    expect3("dbl2", 1'b0, 16'd0, 1'b0);
    run("+1", 1); settle();
    expect3("lead_op", 1'b0, 16'd0, 1'b0);
    run("8+", 1); settle();
    expect3("trail_op", 1'b0, 16'd0, 1'b0);
    run("0*7+0", 1); settle();
    expect3("zeros", 1'b1, 16'd0, 1'b0);
    run("5", 1); settle();
    expect3("pre_clr", 1'b1, 16'd5, 1'b0);
    clr = 1'b1;
    #1;
    expect3("mid_clr", 1'b0, 16'd0, 1'b0);
    clr = 1'b0;
    in = "3";
    settle();
    expect3("after_clr", 1'b1, 16'd3, 1'b0);
    clr = 1'b1;
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
